// File: rtl/sar_pkg.sv
// ---------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the successive-approximation search blocks:
//   - sar_state_t    : FSM state encoding (IDLE / WAIT / DECIDE)
//   - SETTLE_MAX     : largest supported comparator settle time in cycles
//   - SETTLE_W       : width of a settle counter able to hold SETTLE_MAX-1
//   - settle_preload : counter load value for a given settle time
// ---------------------------------------------------------------------------
package sar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_DECIDE = 2'd2
   } sar_state_t;

   localparam int SETTLE_MAX = 7;
   localparam int SETTLE_W   = 3;

   // The counter is loaded with settle-1 and the wait ends in the cycle in
   // which it reads zero, giving exactly 'settle' wait cycles. Settle times
   // outside 1..SETTLE_MAX are clamped (0 means the wait state is skipped).
   function automatic logic [SETTLE_W-1:0] settle_preload(input int settle);
      logic [SETTLE_W-1:0] v;
      if (settle <= 1) begin
         v = '0;
      end else if (settle > SETTLE_MAX) begin
         v = SETTLE_W'(SETTLE_MAX - 1);
      end else begin
         v = SETTLE_W'(settle - 1);
      end
      return v;
   endfunction

endpackage

// File: rtl/sar_settle_timer.sv
// ---------------------------------------------------------------------------
// sar_settle_timer
// Down-counter that times the settle window of a polled external comparator.
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   synchronous active-low reset (counter -> 0)
//   load       in   load load_value (takes priority over count)
//   load_value in   CW-bit preload, i.e. wait cycles minus one
//   count      in   decrement by one while non-zero
//   expire     out  high while the counter reads zero (last wait cycle)
// ---------------------------------------------------------------------------
import sar_pkg::*;

module sar_settle_timer #(
   parameter int CW = SETTLE_W
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          load,
   input  logic [CW-1:0] load_value,
   input  logic          count,
   output logic          expire
);

   logic [CW-1:0] cnt_r;

   // Settle counter: reset, load, or saturating decrement.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_value;
      end else if (count && (cnt_r != '0)) begin
         cnt_r <= cnt_r - CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = (cnt_r == '0);

endmodule

// File: rtl/sar_search8.sv
// ---------------------------------------------------------------------------
// sar_search8
// Successive-approximation search for an unknown value X that is only
// observable through an external unsigned comparator (ge = X >= trial).
// One bit is resolved per (SETTLE+1) cycles, MSB first, so a search takes
// WIDTH*(SETTLE+1) cycles from the accepting edge to the DONE cycle.
// Parameters:
//   WIDTH  width of the searched value (default 8)
//   SETTLE comparator settle cycles after each trial change (0..7)
// Ports:
//   clk     in   rising-edge clock
//   resetn  in   synchronous active-low reset
//   start   in   request a search; only looked at while idle
//   ge      in   comparator result, 1 when X >= trial
//   trial   out  candidate driven to the comparator, held while idle
//   result  out  largest T with X >= T from the last completed search
//   busy    out  high while a search is running
//   done    out  one-cycle pulse when result is updated
// ---------------------------------------------------------------------------
import sar_pkg::*;

module sar_search8 #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             ge,
   output logic [WIDTH-1:0] trial,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
);

   localparam int                  KW             = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [KW-1:0]       K_TOP          = KW'(WIDTH - 1);
   localparam logic [WIDTH-1:0]    TRIAL_INIT     = WIDTH'(1) << (WIDTH - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_PRELOAD = settle_preload(SETTLE);
   localparam logic                HAS_WAIT       = (SETTLE > 0) ? 1'b1 : 1'b0;
   // With no settle time the new trial is decided in the very next cycle.
   localparam sar_state_t          ENTRY_STATE    = (SETTLE > 0) ? ST_WAIT : ST_DECIDE;

   sar_state_t       state_r,  state_s;
   logic [WIDTH-1:0] trial_r,  trial_s;
   logic [WIDTH-1:0] result_r, result_s;
   logic [KW-1:0]    k_r,      k_s;
   logic             busy_r,   busy_s;
   logic             done_r,   done_s;
   logic [WIDTH-1:0] dec_trial_s;
   logic             tmr_load_s;
   logic             tmr_count_s;
   logic             tmr_expire_s;

   sar_settle_timer #(
      .CW (SETTLE_W)
   ) u_settle (
      .clk        (clk),
      .resetn     (resetn),
      .load       (tmr_load_s),
      .load_value (SETTLE_PRELOAD),
      .count      (tmr_count_s),
      .expire     (tmr_expire_s)
   );

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r  <= ST_IDLE;
         trial_r  <= '0;
         result_r <= '0;
         k_r      <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         trial_r  <= trial_s;
         result_r <= result_s;
         k_r      <= k_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
      end
   end

   // Next-state logic: trial only moves when leaving IDLE or DECIDE.
   always_comb begin
      state_s     = state_r;
      trial_s     = trial_r;
      result_s    = result_r;
      k_s         = k_r;
      busy_s      = busy_r;
      done_s      = 1'b0;
      tmr_load_s  = 1'b0;
      tmr_count_s = 1'b0;
      dec_trial_s = trial_r;

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               trial_s    = TRIAL_INIT;
               k_s        = K_TOP;
               busy_s     = 1'b1;
               state_s    = ENTRY_STATE;
               tmr_load_s = HAS_WAIT;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_WAIT: begin
            // ge is deliberately not looked at here; it may still be moving.
            if (tmr_expire_s) begin
               state_s = ST_DECIDE;
            end else begin
               tmr_count_s = 1'b1;
            end
         end

         ST_DECIDE: begin
            // Keep bit k if X >= trial, otherwise drop it.
            dec_trial_s[k_r] = ge;
            if (k_r != '0) begin
               k_s                          = k_r - KW'(1);
               dec_trial_s[k_r - KW'(1)]    = 1'b1;
               state_s                      = ENTRY_STATE;
               tmr_load_s                   = HAS_WAIT;
            end else begin
               result_s = dec_trial_s;
               done_s   = 1'b1;
               busy_s   = 1'b0;
               state_s  = ST_IDLE;
            end
            trial_s = dec_trial_s;
         end

         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   assign trial  = trial_r;
   assign result = result_r;
   assign busy   = busy_r;
   assign done   = done_r;

endmodule

// File: tb/tb_sar_search8.sv
// ---------------------------------------------------------------------------
// tb_sar_search8
// Three instances share one clock: index 0 has SETTLE=1, index 1 SETTLE=0,
// index 2 SETTLE=3. Each instance gets its own comparator built from a bench
// variable x. The reference model is plain binary search arithmetic: the
// expected trial for bit j is the bits already kept OR (1<<j), the expected
// result is x itself, and DONE lands 8*(SETTLE+1) cycles after acceptance.
// ---------------------------------------------------------------------------
module tb_sar_search8;

   logic       clk;
   logic       resetn_v [3];
   logic       start_v  [3];
   logic       glitch_v [3];
   logic [7:0] x_v      [3];
   logic       ge_w     [3];
   logic [7:0] trial_w  [3];
   logic [7:0] result_w [3];
   logic       busy_w   [3];
   logic       done_w   [3];

   int n_cmp;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      // External comparator, optionally inverted to model a settling glitch.
      assign ge_w[g] = glitch_v[g] ^ (x_v[g] >= trial_w[g]);

      sar_search8 #(
         .WIDTH  (8),
         .SETTLE ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
      ) dut (
         .clk    (clk),
         .resetn (resetn_v[g]),
         .start  (start_v[g]),
         .ge     (ge_w[g]),
         .trial  (trial_w[g]),
         .result (result_w[g]),
         .busy   (busy_w[g]),
         .done   (done_w[g])
      );
   end

   function automatic int settle_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
   endfunction

   task automatic check(input string name, input int d, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (dut %0d) at %0t: got %0h expected %0h", name, d, $time, act, exp);
      end
   endtask

   // One idle cycle (checking the previous DONE was a single pulse), then
   // present x and raise start so the next edge accepts the search.
   task automatic launch(input int d, input logic [7:0] xv);
      @(negedge clk);
      check("done_single", d, done_w[d], 0);
      x_v[d]     = xv;
      start_v[d] = 1'b1;
   endtask

   // Follows a search whose accepting edge is the next posedge. Cycle c is
   // the cycle after accepting edge + c. hold keeps start high the whole
   // time and swaps x to x_next in the DONE cycle for a back-to-back run.
   task automatic run_search(input int d, input logic [7:0] xv, input bit hold,
                             input logic [7:0] x_next, input int repulse_at,
                             input bit glitch);
      int         s;
      int         l;
      logic [7:0] seq [8];
      logic [7:0] kept;
      logic [7:0] t;
      s    = settle_of(d);
      l    = 8 * (s + 1);
      kept = 8'd0;
      for (int j = 7; j >= 0; j--) begin
         t          = kept | (8'd1 << j);
         seq[7 - j] = t;
         if (xv >= t) kept = t;
      end
      for (int c = 0; c <= l; c++) begin
         @(negedge clk);
         if (c < l) begin
            check("trial", d, trial_w[d], seq[c / (s + 1)]);
            check("busy",  d, busy_w[d], 1);
            check("done_early", d, done_w[d], 0);
         end else begin
            check("done",   d, done_w[d], 1);
            check("busy_end", d, busy_w[d], 0);
            check("result", d, result_w[d], xv);
            check("trial_final", d, trial_w[d], xv);
         end
         if (glitch && (c < l) && ((c % (s + 1)) != s)) begin
            glitch_v[d] = 1'($urandom_range(0, 1));
         end else begin
            glitch_v[d] = 1'b0;
         end
         if (hold) begin
            if (c == l) x_v[d] = x_next;
         end else begin
            start_v[d] = (c == repulse_at) ? 1'b1 : 1'b0;
         end
      end
   endtask

   typedef struct {
      int         d;
      logic [7:0] x;
      int         repulse;
      bit         glitch;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic [7:0] rx;
      n_cmp  = 0;
      n_fail = 0;
      for (int i = 0; i < 3; i++) begin
         resetn_v[i] = 1'b0;
         start_v[i]  = 1'b0;
         glitch_v[i] = 1'b0;
         x_v[i]      = 8'h00;
      end

      vecs[0] = '{0, 8'h5A, -1, 1'b0};
      vecs[1] = '{1, 8'h00, -1, 1'b0};
      vecs[2] = '{1, 8'hFF, -1, 1'b0};
      vecs[3] = '{0, 8'h37,  5, 1'b0};
      vecs[4] = '{2, 8'hA5, -1, 1'b1};
      vecs[5] = '{2, 8'h01, -1, 1'b1};
      vecs[6] = '{1, 8'h80,  3, 1'b0};

      // Reset state.
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("rst_trial",  i, trial_w[i], 0);
         check("rst_result", i, result_w[i], 0);
         check("rst_busy",   i, busy_w[i], 0);
         check("rst_done",   i, done_w[i], 0);
         resetn_v[i] = 1'b1;
      end

      // Directed table.
      for (int v = 0; v < 7; v++) begin
         launch(vecs[v].d, vecs[v].x);
         run_search(vecs[v].d, vecs[v].x, 1'b0, 8'h00, vecs[v].repulse, vecs[v].glitch);
      end

      // Back-to-back with start held high through DONE.
      launch(0, 8'h10);
      run_search(0, 8'h10, 1'b1, 8'hC3, -1, 1'b0);
      run_search(0, 8'hC3, 1'b0, 8'h00, -1, 1'b0);

      // Reset at cycle 5 of a search, then start on the first released edge.
      launch(0, 8'h37);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         start_v[0] = 1'b0;
      end
      resetn_v[0] = 1'b0;
      @(negedge clk);
      check("abort_busy",   0, busy_w[0], 0);
      check("abort_trial",  0, trial_w[0], 0);
      check("abort_result", 0, result_w[0], 0);
      check("abort_done",   0, done_w[0], 0);
      resetn_v[0] = 1'b1;
      x_v[0]      = 8'h80;
      start_v[0]  = 1'b1;
      run_search(0, 8'h80, 1'b0, 8'h00, -1, 1'b0);

      // Randomised searches against the arithmetic model.
      for (int i = 0; i < 24; i++) begin
         int d;
         d  = i % 3;
         rx = 8'($urandom_range(0, 255));
         launch(d, rx);
         run_search(d, rx, 1'b0, 8'h00, (i % 4 == 1) ? 2 : -1, 1'b1);
      end

      @(negedge clk);
      check("done_last", 0, done_w[0], 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
